// File: rtl/mips_isa_pkg.sv
// MIPS instruction-kind enumeration, opcode/funct constants and loader FSM states
// shared by the program-loader encoder and the single-cycle control unit.
package mips_isa_pkg;

  typedef enum logic [4:0] {
    K_ADD  = 5'd0,  K_SUB  = 5'd1,  K_AND  = 5'd2,  K_OR   = 5'd3,
    K_XOR  = 5'd4,  K_SLL  = 5'd5,  K_SRL  = 5'd6,  K_SRA  = 5'd7,
    K_JR   = 5'd8,  K_ADDI = 5'd9,  K_ANDI = 5'd10, K_ORI  = 5'd11,
    K_XORI = 5'd12, K_LW   = 5'd13, K_SW   = 5'd14, K_BEQ  = 5'd15,
    K_BNE  = 5'd16, K_LUI  = 5'd17, K_J    = 5'd18, K_JAL  = 5'd19
  } kind_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_FULL = 2'd3
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;

endpackage

// File: rtl/mips_word_pack.sv
// Combinational packer: instruction kind plus operand fields to a 32-bit MIPS word.
// Fields a format does not use are forced to zero; kinds 20-31 flag illegal.
module mips_word_pack
  import mips_isa_pkg::*;
(
  input  logic [4:0]  i_kind,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_sa,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  function automatic logic [31:0] r_fmt(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sa,
                                        input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] i_fmt(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  always_comb begin
    o_word    = '0;
    o_illegal = 1'b0;
    case (i_kind)
      K_ADD:  o_word = r_fmt(i_rs, i_rt, i_rd, 5'd0, FN_ADD);
      K_SUB:  o_word = r_fmt(i_rs, i_rt, i_rd, 5'd0, FN_SUB);
      K_AND:  o_word = r_fmt(i_rs, i_rt, i_rd, 5'd0, FN_AND);
      K_OR:   o_word = r_fmt(i_rs, i_rt, i_rd, 5'd0, FN_OR);
      K_XOR:  o_word = r_fmt(i_rs, i_rt, i_rd, 5'd0, FN_XOR);
      K_SLL:  o_word = r_fmt(5'd0, i_rt, i_rd, i_sa, FN_SLL);
      K_SRL:  o_word = r_fmt(5'd0, i_rt, i_rd, i_sa, FN_SRL);
      K_SRA:  o_word = r_fmt(5'd0, i_rt, i_rd, i_sa, FN_SRA);
      K_JR:   o_word = r_fmt(i_rs, 5'd0, 5'd0, 5'd0, FN_JR);
      K_ADDI: o_word = i_fmt(OP_ADDI, i_rs, i_rt, i_imm);
      K_ANDI: o_word = i_fmt(OP_ANDI, i_rs, i_rt, i_imm);
      K_ORI:  o_word = i_fmt(OP_ORI,  i_rs, i_rt, i_imm);
      K_XORI: o_word = i_fmt(OP_XORI, i_rs, i_rt, i_imm);
      K_LW:   o_word = i_fmt(OP_LW,   i_rs, i_rt, i_imm);
      K_SW:   o_word = i_fmt(OP_SW,   i_rs, i_rt, i_imm);
      K_BEQ:  o_word = i_fmt(OP_BEQ,  i_rs, i_rt, i_imm);
      K_BNE:  o_word = i_fmt(OP_BNE,  i_rs, i_rt, i_imm);
      K_LUI:  o_word = i_fmt(OP_LUI,  5'd0, i_rt, i_imm);
      K_J:    o_word = {OP_J,   i_target};
      K_JAL:  o_word = {OP_JAL, i_target};
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: accepts instruction requests, encodes them and writes them to
// sequential instruction-memory words, holding each write until it is acknowledged.
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_sa,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              wr_ack,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              full,
  output logic              error
);

  state_e          r_state;
  logic            r_last_taken;
  logic [31:0]     w_word;
  logic            w_illegal;
  logic            w_accept;
  logic            w_acked;
  logic            w_hit_depth;
  logic [ADDR_W:0] w_cnt_inc;

  mips_word_pack u_pack (
    .i_kind    (in_kind),
    .i_rs      (in_rs),
    .i_rt      (in_rt),
    .i_rd      (in_rd),
    .i_sa      (in_sa),
    .i_imm     (in_imm),
    .i_target  (in_target),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  assign in_ready    = (r_state == S_LOAD) & (~wr_en | wr_ack) & ~r_last_taken;
  assign w_accept    = in_valid & in_ready;
  assign w_acked     = wr_en & wr_ack;
  assign w_cnt_inc   = count + {{ADDR_W{1'b0}}, w_acked};
  assign w_hit_depth = w_acked & (w_cnt_inc == (ADDR_W+1)'(DEPTH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_taken <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      count        <= '0;
      done         <= 1'b0;
      full         <= 1'b0;
      error        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        r_state      <= S_LOAD;
        r_last_taken <= 1'b0;
        wr_en        <= 1'b0;
        count        <= '0;
        full         <= 1'b0;
        error        <= 1'b0;
      end else begin
        case (r_state)
          S_LOAD: begin
            count <= w_cnt_inc;
            if (w_acked) wr_en <= 1'b0;
            // A word accepted on the same edge as an ack lands at the post-ack address.
            if (w_accept) begin
              if (in_last) r_last_taken <= 1'b1;
              if (w_illegal) begin
                error <= 1'b1;
              end else begin
                wr_en   <= 1'b1;
                wr_addr <= w_cnt_inc[ADDR_W-1:0];
                wr_data <= w_word;
              end
            end
            if (w_acked && r_last_taken) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else if (w_accept && in_last && w_illegal && (!wr_en || w_acked)) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else if (w_hit_depth) begin
              r_state <= S_FULL;
              full    <= 1'b1;
              wr_en   <= 1'b0;
            end
          end
          S_DONE: begin
            r_state      <= S_IDLE;
            r_last_taken <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for the MIPS program loader with hand-encoded expected words.
module tb_mips_instr_encoder;
  import mips_isa_pkg::*;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4:0]        in_kind = '0;
  logic [4:0]        in_rs = '0;
  logic [4:0]        in_rt = '0;
  logic [4:0]        in_rd = '0;
  logic [4:0]        in_sa = '0;
  logic [15:0]       in_imm = '0;
  logic [25:0]       in_target = '0;
  logic              in_last = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              wr_ack = 1'b0;
  logic [ADDR_W:0]   count;
  logic              done;
  logic              full;
  logic              error;

  int n_asserts = 0;
  int n_fail    = 0;

  mips_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_sa(in_sa),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .count(count), .done(done),
    .full(full), .error(error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic req(input logic [4:0] k, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm,
                     input logic [25:0] tgt, input logic last);
    in_valid  = 1'b1;
    in_kind   = k;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_sa     = sa;
    in_imm    = imm;
    in_target = tgt;
    in_last   = last;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_wr_en",    32'(wr_en),    32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_count",    32'(count),    32'd0);
    check("rst_wr_data",  wr_data,       32'd0);
    check("rst_flags",    32'({done, full, error}), 32'd0);
    reset = 1'b0;
    tick();

    // add r3 = r1 + r2, held until acked
    pulse_start();
    check("load_ready", 32'(in_ready), 32'd1);
    req(K_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    check("add_wr_en",   32'(wr_en),   32'd1);
    check("add_wr_addr", 32'(wr_addr), 32'd0);
    check("add_wr_data", wr_data,      32'h00221820);
    tick();
    check("add_held_en",   32'(wr_en), 32'd1);
    check("add_held_data", wr_data,    32'h00221820);
    wr_ack = 1'b1;
    #1;
    check("add_ack_ready", 32'(in_ready), 32'd1);
    tick();
    wr_ack = 1'b0;
    check("add_done_en", 32'(wr_en), 32'd0);
    check("add_count",   32'(count), 32'd1);

    // lw then sra back-to-back with ack held high
    pulse_start();
    check("restart_count", 32'(count), 32'd0);
    wr_ack = 1'b1;
    req(K_LW, 5'd5, 5'd4, 5'd0, 5'd0, 16'h0008, 26'h0, 1'b0);
    tick();
    check("lw_data", wr_data,      32'h8CA40008);
    check("lw_addr", 32'(wr_addr), 32'd0);
    req(K_SRA, 5'd7, 5'd3, 5'd2, 5'd4, 16'h0, 26'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    check("sra_data",  wr_data,      32'h00031103);
    check("sra_addr",  32'(wr_addr), 32'd1);
    check("sra_count", 32'(count),   32'd1);
    tick();
    check("pair_count", 32'(count), 32'd2);
    check("pair_en",    32'(wr_en), 32'd0);

    // beq then jal marked last; done pulses for one cycle
    pulse_start();
    req(K_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0);
    tick();
    check("beq_data", wr_data, 32'h1022FFFF);
    req(K_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("jal_data",       wr_data,       32'h0C000010);
    check("jal_addr",       32'(wr_addr),  32'd1);
    check("after_last_rdy", 32'(in_ready), 32'd0);
    check("jal_no_done",    32'(done),     32'd0);
    tick();
    check("done_pulse",  32'(done),  32'd1);
    check("done_count",  32'(count), 32'd2);
    tick();
    check("done_cleared", 32'(done),     32'd0);
    check("idle_ready",   32'(in_ready), 32'd0);

    // illegal kind sets error, following ori lands at address 0
    pulse_start();
    req(5'd25, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    tick();
    check("illegal_error", 32'(error), 32'd1);
    check("illegal_no_wr", 32'(wr_en), 32'd0);
    req(K_ORI, 5'd1, 5'd2, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    check("ori_data", wr_data,      32'h34221234);
    check("ori_addr", 32'(wr_addr), 32'd0);
    tick();
    check("ori_count", 32'(count), 32'd1);
    check("err_sticky", 32'(error), 32'd1);
    pulse_start();
    check("start_clr_err", 32'(error), 32'd0);

    // illegal kind carrying in_last with nothing pending finishes the session
    req(5'd20, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("ill_last_done",  32'(done),  32'd1);
    check("ill_last_wr_en", 32'(wr_en), 32'd0);
    check("ill_last_count", 32'(count), 32'd0);
    tick();

    // DEPTH words without in_last: full after the 4th ack, 5th never written
    pulse_start();
    req(K_XOR, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 1'b0);
    tick();
    tick();
    tick();
    tick();
    check("fill_addr3", 32'(wr_addr), 32'd3);
    check("fill_full0", 32'(full),    32'd0);
    tick();
    check("full_set",    32'(full),     32'd1);
    check("full_count",  32'(count),    32'd4);
    check("full_wr_en",  32'(wr_en),    32'd0);
    check("full_ready",  32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    check("full_no_5th", 32'(wr_en), 32'd0);
    check("full_sticky", 32'(full),  32'd1);
    pulse_start();
    check("start_clr_full", 32'(full), 32'd0);

    // stall with wr_ack low, then reset mid-stall
    wr_ack = 1'b0;
    req(K_SUB, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b0);
    tick();
    check("sub_data", wr_data, 32'h00853022);
    req(K_AND, 5'd9, 5'd9, 5'd9, 5'd0, 16'h0, 26'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ready", 32'(in_ready), 32'd0);
      check("stall_data",  wr_data,       32'h00853022);
      check("stall_addr",  32'(wr_addr),  32'd0);
      check("stall_en",    32'(wr_en),    32'd1);
    end
    #2;
    reset = 1'b1;
    #1;
    check("midrst_wr_en", 32'(wr_en),    32'd0);
    check("midrst_data",  wr_data,       32'd0);
    check("midrst_count", 32'(count),    32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    check("midrst_flags", 32'({done, full, error}), 32'd0);
    in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
